// File: rtl/mc_pkg.sv
// Shared constants, state encoding and helpers
// for the motor-command arbiter.
package mc_pkg;

  localparam logic [4:0] MC_NEUTRAL = 5'b11101;

  localparam logic [1:0] DIR_ILLEGAL = 2'b00;
  localparam logic [1:0] DIR_NEUTRAL = 2'b01;
  localparam logic [1:0] DIR_FWD     = 2'b10;
  localparam logic [1:0] DIR_REV     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Lowest set bit wins: bit0 is the highest priority.
  function automatic logic [2:0] prio_pick(
    input logic [2:0] v
  );
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/mc_command_arbiter_if.sv
// Requester/modulator bundle of the arbiter.
// master = requesters + modulator, slave = arbiter.
interface mc_command_arbiter_if;
  logic [2:0] req_valid;
  logic [4:0] req_mc0;
  logic [4:0] req_mc1;
  logic [4:0] req_mc2;
  logic [4:0] current_mc;
  logic [4:0] desired_mc;
  logic [2:0] grant;
  logic       busy;
  logic       fault;
  logic       illegal_cmd;

  modport master (
    output req_valid, req_mc0, req_mc1,
    output req_mc2, current_mc,
    input  desired_mc, grant, busy,
    input  fault, illegal_cmd
  );

  modport slave (
    input  req_valid, req_mc0, req_mc1,
    input  req_mc2, current_mc,
    output desired_mc, grant, busy,
    output fault, illegal_cmd
  );
endinterface

// File: rtl/mc_convergence_timer.sv
// Saturating watchdog counting cycles without
// convergence; expired fires on the LIMIT-th one.
module mc_convergence_timer #(
  parameter int unsigned LIMIT = 26_400_000,
  parameter int unsigned CNT_W = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] TOP =
    CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != TOP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clear_i &&
                     (cnt_q == LAST);
endmodule

// File: rtl/mc_command_arbiter.sv
// Three-way priority arbiter driving the target
// motor command, with convergence watchdog.
module mc_command_arbiter
  import mc_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 26_400_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  mc_command_arbiter_if.slave bus
);
  state_e     state_q, state_pre, state_d;
  logic [2:0] grant_q, grant_pre, grant_d;
  logic [4:0] des_q, des_pre, des_d;
  logic       busy_q, busy_d;
  logic       fault_q, fault_d;
  logic       ill_q, ill_pre, ill_d;
  logic [2:0] hp;
  logic [4:0] sel_mc;
  logic       own_valid, preempt, cur_neutral;
  logic       wd_en, wd_clr, wd_exp;

  assign hp          = prio_pick(bus.req_valid);
  assign own_valid   = |(bus.req_valid & grant_q);
  assign preempt     = (hp != 3'b000) &&
                       (hp < grant_q);
  assign cur_neutral = bus.current_mc == MC_NEUTRAL;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      des_q   <= MC_NEUTRAL;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      des_q   <= des_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin : next_state
    state_pre = state_q;
    grant_pre = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hp != 3'b000) begin
          state_pre = ST_SERVE;
          grant_pre = hp;
        end
      end
      ST_SERVE: begin
        if (preempt) begin
          grant_pre = hp;
        end else if (!own_valid) begin
          state_pre = ST_DRAIN;
          grant_pre = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.req_valid[0]) begin
          state_pre = ST_SERVE;
          grant_pre = 3'b001;
        end else if (cur_neutral) begin
          state_pre = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (cur_neutral &&
            bus.req_valid == 3'b000) begin
          state_pre = ST_IDLE;
        end
      end
      default: begin
        state_pre = ST_IDLE;
        grant_pre = '0;
      end
    endcase
  end

  // Only a continuing SERVE tracks the owner;
  // entry from IDLE/DRAIN starts from neutral.
  always_comb begin : outputs
    sel_mc  = MC_NEUTRAL;
    des_pre = MC_NEUTRAL;
    ill_pre = 1'b0;
    unique case (1'b1)
      grant_pre[0]: sel_mc = bus.req_mc0;
      grant_pre[1]: sel_mc = bus.req_mc1;
      grant_pre[2]: sel_mc = bus.req_mc2;
      default:      sel_mc = MC_NEUTRAL;
    endcase
    if (state_q == ST_SERVE &&
        state_pre == ST_SERVE) begin
      if (sel_mc[1:0] == DIR_ILLEGAL) begin
        ill_pre = 1'b1;
      end else begin
        des_pre = sel_mc;
      end
    end
  end

  assign wd_en  = (state_q == ST_SERVE ||
                   state_q == ST_DRAIN) &&
                  (bus.current_mc != des_q);
  assign wd_clr = !wd_en ||
                  (state_pre != state_q) ||
                  (des_pre != des_q);

  mc_convergence_timer #(
    .LIMIT (WDOG_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (wd_en),
    .clear_i   (wd_clr),
    .expired_o (wd_exp)
  );

  assign state_d = wd_exp ? ST_FAULT : state_pre;
  assign grant_d = wd_exp ? 3'b000 : grant_pre;
  assign des_d   = wd_exp ? MC_NEUTRAL : des_pre;
  assign ill_d   = ill_pre && !wd_exp;
  assign busy_d  = bus.current_mc != des_q;
  assign fault_d = state_d == ST_FAULT;

  assign bus.desired_mc  = des_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;
  assign bus.illegal_cmd = ill_q;
endmodule

// File: tb/tb_mc_command_arbiter.sv
// Directed scenarios plus randomized run against
// a behavioural model of the arbiter rules.
module tb_mc_command_arbiter;
  localparam int W = 20;
  localparam logic [4:0] N = 5'b11101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  mc_command_arbiter_if bus();

  mc_command_arbiter #(
    .WDOG_CYCLES (W),
    .CNT_W       (5)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model: st 0 idle, 1 serve, 2 drain, 3 fault;
  // owner is requester index or -1.
  int m_st, m_own, m_run;
  logic [4:0] m_des;
  logic m_busy, m_fault, m_ill;

  always @(posedge clk) begin : model
    int st, own, hp;
    logic [4:0] des;
    logic [4:0] mcs [3];
    logic ill, act, ex;
    mcs[0] = bus.req_mc0;
    mcs[1] = bus.req_mc1;
    mcs[2] = bus.req_mc2;
    if (!rst_n) begin
      m_st = 0; m_own = -1; m_run = 0;
      m_des = N; m_busy = 0;
      m_fault = 0; m_ill = 0;
    end else begin
      hp = -1;
      for (int i = 2; i >= 0; i--)
        if (bus.req_valid[i]) hp = i;
      st = m_st; own = m_own;
      des = N; ill = 0;
      case (m_st)
        0: if (hp >= 0) begin
             st = 1; own = hp;
           end
        1: begin
             if (hp >= 0 && hp < own) own = hp;
             else if (!bus.req_valid[own]) begin
               st = 2; own = -1;
             end
             if (st == 1) begin
               if (mcs[own][1:0] == 2'b00) ill = 1;
               else des = mcs[own];
             end
           end
        2: if (bus.req_valid[0]) begin
             st = 1; own = 0;
           end else if (bus.current_mc == N) st = 0;
        default:
           if (bus.current_mc == N &&
               bus.req_valid == 0) st = 0;
      endcase
      act = (m_st == 1 || m_st == 2) &&
            bus.current_mc != m_des;
      ex = 0;
      if (act && st == m_st && des == m_des) begin
        m_run++;
        if (m_run == W) begin
          ex = 1; m_run = 0;
        end
      end else m_run = 0;
      m_busy = bus.current_mc != m_des;
      m_des  = ex ? N : des;
      m_st   = ex ? 3 : st;
      m_own  = ex ? -1 : own;
      m_ill  = ill && !ex;
      m_fault = m_st == 3;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.req_valid = 0;
    bus.req_mc0 = N;
    bus.req_mc1 = N;
    bus.req_mc2 = N;
    bus.current_mc = N;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    bus.current_mc = 5'b01010;
    bus.req_valid = 3'b111;
    rst_n = 0;
    step();
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL rst_des got=%b exp=%b", bus.desired_mc, N); end
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL rst_grant got=%b exp=000", bus.grant); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%b exp=0", bus.fault); end
    n_tests++; if (bus.illegal_cmd !== 1'b0) begin n_fail++; $display("FAIL rst_ill got=%b exp=0", bus.illegal_cmd); end
  endtask

  task automatic test_grant();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_mc1 = 5'b01110;
    step();
    n_tests++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL grant1 got=%b exp=010", bus.grant); end
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL grant_des1 got=%b exp=%b", bus.desired_mc, N); end
    step();
    n_tests++; if (bus.desired_mc !== 5'b01110) begin n_fail++; $display("FAIL grant_des2 got=%b exp=01110", bus.desired_mc); end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req_valid = 3'b100;
    bus.req_mc2 = 5'b10010;
    step();
    step();
    n_tests++; if (bus.desired_mc !== 5'b10010) begin n_fail++; $display("FAIL pre_own got=%b exp=10010", bus.desired_mc); end
    bus.req_mc0 = 5'b11111;
    bus.req_valid = 3'b101;
    step();
    n_tests++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL pre_grant got=%b exp=001", bus.grant); end
    n_tests++; if (bus.desired_mc !== 5'b11111) begin n_fail++; $display("FAIL pre_des got=%b exp=11111", bus.desired_mc); end
    bus.req_valid = 3'b011;
    step();
    n_tests++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL lowpri got=%b exp=001", bus.grant); end
  endtask

  task automatic test_drain();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_mc1 = 5'b01110;
    step();
    step();
    bus.current_mc = 5'b01110;
    step();
    bus.req_valid = 3'b000;
    step();
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL drain_des got=%b exp=%b", bus.desired_mc, N); end
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL drain_grant got=%b exp=000", bus.grant); end
    bus.req_valid = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL drain_wait%0d got=%b exp=000", i, bus.grant); end
    end
    bus.current_mc = N;
    bus.req_valid = 3'b100;
    step();
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL drain_idle got=%b exp=000", bus.grant); end
    step();
    n_tests++; if (bus.grant !== 3'b100) begin n_fail++; $display("FAIL idle_grant got=%b exp=100", bus.grant); end
  endtask

  task automatic test_drain_bit0();
    do_reset();
    bus.req_valid = 3'b100;
    bus.req_mc2 = 5'b01010;
    step();
    bus.current_mc = 5'b01010;
    bus.req_valid = 3'b000;
    step();
    bus.req_valid = 3'b001;
    bus.req_mc0 = 5'b01011;
    step();
    n_tests++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL drain_b0 got=%b exp=001", bus.grant); end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_mc1 = 5'b01110;
    step();
    step();
    bus.req_mc1 = 5'b01100;
    step();
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL ill_des got=%b exp=%b", bus.desired_mc, N); end
    n_tests++; if (bus.illegal_cmd !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got=%b exp=1", bus.illegal_cmd); end
    n_tests++; if (bus.grant !== 3'b010) begin n_fail++; $display("FAIL ill_grant got=%b exp=010", bus.grant); end
    bus.req_mc1 = 5'b01110;
    step();
    n_tests++; if (bus.illegal_cmd !== 1'b0) begin n_fail++; $display("FAIL ill_end got=%b exp=0", bus.illegal_cmd); end
    n_tests++; if (bus.desired_mc !== 5'b01110) begin n_fail++; $display("FAIL ill_resume got=%b exp=01110", bus.desired_mc); end
  endtask

  task automatic test_watchdog();
    logic ef;
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_mc1 = 5'b01110;
    step();
    step();
    for (int i = 1; i <= W; i++) begin
      step();
      ef = (i == W);
      n_tests++; if (bus.fault !== ef) begin n_fail++; $display("FAIL wdog_c%0d got=%b exp=%b", i, bus.fault, ef); end
    end
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL wdog_des got=%b exp=%b", bus.desired_mc, N); end
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL wdog_grant got=%b exp=000", bus.grant); end
    step();
    n_tests++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold1 got=%b exp=1", bus.fault); end
    bus.req_valid = 3'b000;
    bus.current_mc = 5'b01110;
    step();
    n_tests++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL fault_hold2 got=%b exp=1", bus.fault); end
    bus.current_mc = N;
    step();
    n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL fault_exit got=%b exp=0", bus.fault); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_mc0 = 5'b10110;
    step();
    step();
    bus.current_mc = 5'b01110;
    rst_n = 0;
    step();
    n_tests++; if (bus.desired_mc !== N) begin n_fail++; $display("FAIL mrst_des got=%b exp=%b", bus.desired_mc, N); end
    n_tests++; if (bus.grant !== 3'b000) begin n_fail++; $display("FAIL mrst_grant got=%b exp=000", bus.grant); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", bus.busy); end
    rst_n = 1;
    step();
    n_tests++; if (bus.grant !== 3'b001) begin n_fail++; $display("FAIL mrst_regrant got=%b exp=001", bus.grant); end
  endtask

  task automatic test_random();
    logic [11:0] got, exp;
    logic [2:0] eg;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 9) < 3)
        bus.req_valid = ($urandom_range(0, 3) == 0) ?
          3'b000 : 3'($urandom);
      if ($urandom_range(0, 9) < 3) bus.req_mc0 = 5'($urandom);
      if ($urandom_range(0, 9) < 3) bus.req_mc1 = 5'($urandom);
      if ($urandom_range(0, 9) < 3) bus.req_mc2 = 5'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus.current_mc = m_des;
        4, 5, 6:    bus.current_mc = N;
        7:          bus.current_mc = 5'($urandom);
        default:    ;
      endcase
      step();
      eg = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
      exp = {m_des, eg, m_busy, m_fault, m_ill};
      got = {bus.desired_mc, bus.grant, bus.busy,
             bus.fault, bus.illegal_cmd};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rand_c%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_preempt();
    test_drain();
    test_drain_bit0();
    test_illegal();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
